adc_pattern_gen: RTL and testbench

Synthesizable multi-channel ADC test-pattern and trigger source. It replaces the live ADC front-end stream when the board runs in self-test or loopback mode. It produces CN channels of DW-bit samples on a valid/ready stream with selectable patterns: constant, ramp, walking-one and bounded sawtooth. It also produces a periodic trigger pulse with programmable period and width, and feeds the oscilloscope/acquisition path in place of the ADC deserializer output.

---
 rtl/adc_pattern_pkg.sv | 47 ++++
 rtl/adc_pattern_gen_trg.sv | 39 +++
 rtl/adc_pattern_gen.sv | 153 +++++++++++++++
 tb/tb_adc_pattern_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pattern_pkg.sv
// Shared types for the ADC test-pattern generator: pattern modes,
// FSM states, latched configuration bundle and first-sample helper.
package adc_pattern_pkg;

    localparam int CN_DEF = 2;
    localparam int DW_DEF = 14;
    localparam int PW_DEF = 32;
    localparam int LW_DEF = 16;

    typedef enum logic [1:0] {
        PAT_CONST = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_WALK  = 2'd2,
        PAT_SAW   = 2'd3
    } pat_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_e;

    typedef struct packed {
        pat_mode_e           mode;
        logic [DW_DEF-1:0]   val;
        logic [DW_DEF-1:0]   step;
        logic [LW_DEF-1:0]   len;
        logic [CN_DEF-1:0]   inv;
        logic [PW_DEF-1:0]   per;
        logic [PW_DEF-1:0]   tlen;
    } cfg_t;

    // Sample presented with the first beat after start.
    function automatic logic [DW_DEF-1:0] first_sample(
        input pat_mode_e         m,
        input logic [DW_DEF-1:0] v
    );
        logic [DW_DEF-1:0] r;
        r = v;
        if (m == PAT_WALK && v == '0)
            r = DW_DEF'(1);
        else if (m == PAT_SAW)
            r = '0;
        return r;
    endfunction

endpackage

// File: rtl/adc_pattern_gen_trg.sv
// Periodic trigger: free-running period counter with registered pulse.
// Ports: clk_i/rstn_i, en_i (count), clr_i (restart), per_i, len_i, trg_o.
module adc_pattern_trg #(
    parameter int PW = 32
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic [PW-1:0] per_i,
    input  logic [PW-1:0] len_i,
    output logic          trg_o
);

    logic [PW-1:0] tc_q;
    logic          trg_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tc_q  <= '0;
            trg_q <= 1'b0;
        end else if (clr_i) begin
            tc_q  <= '0;
            trg_q <= 1'b0;
        end else if (en_i) begin
            trg_q <= (per_i != '0) && (tc_q < len_i);
            if (per_i == '0 || tc_q == per_i - PW'(1))
                tc_q <= '0;
            else
                tc_q <= tc_q + PW'(1);
        end else begin
            // Counter holds; pulse is forced low outside RUN.
            trg_q <= 1'b0;
        end
    end

    assign trg_o = trg_q;

endmodule

// File: rtl/adc_pattern_gen.sv
// Multi-channel ADC test-pattern source with valid/ready stream and trigger.
// Ports: ctl_* start/stop, cfg_* pattern/trigger config, sts_* status,
// m_t* sample stream (channel c at [c*DW +: DW]), trg_o trigger pulse.
module adc_pattern_gen
    import adc_pattern_pkg::*;
#(
    parameter int CN = CN_DEF,
    parameter int DW = DW_DEF,
    parameter int PW = PW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic           ctl_start_i,
    input  logic           ctl_stop_i,
    input  logic [1:0]     cfg_mode_i,
    input  logic [DW-1:0]  cfg_val_i,
    input  logic [DW-1:0]  cfg_step_i,
    input  logic [LW-1:0]  cfg_len_i,
    input  logic [CN-1:0]  cfg_inv_i,
    input  logic [PW-1:0]  cfg_trg_per_i,
    input  logic [PW-1:0]  cfg_trg_len_i,
    output logic           sts_run_o,
    output logic [31:0]    sts_cnt_o,
    output logic [CN*DW-1:0] m_tdata_o,
    output logic           m_tvalid_o,
    input  logic           m_tready_i,
    output logic           trg_o
);

    state_e        state_q;
    cfg_t          cfg_q;
    cfg_t          cfg_d;
    logic [DW-1:0] v_q;
    logic [DW-1:0] v_d;
    logic [LW-1:0] idx_q;
    logic [LW-1:0] idx_d;
    logic [31:0]   cnt_q;
    logic          tvalid_q;
    logic          hs;
    logic          start_ok;
    logic          saw_last;
    logic          trg_en;

    assign hs       = tvalid_q && m_tready_i;
    assign start_ok = (state_q == IDLE) && ctl_start_i && !ctl_stop_i;
    assign trg_en   = (state_q == RUN) && !ctl_stop_i;

    always_comb begin
        cfg_d      = '0;
        cfg_d.mode = pat_mode_e'(cfg_mode_i);
        cfg_d.val  = cfg_val_i;
        cfg_d.step = cfg_step_i;
        cfg_d.len  = cfg_len_i;
        cfg_d.inv  = cfg_inv_i;
        cfg_d.per  = cfg_trg_per_i;
        cfg_d.tlen = cfg_trg_len_i;
    end

    // Next sample on handshake; len==0 behaves like len==1.
    always_comb begin
        v_d      = v_q;
        idx_d    = idx_q;
        saw_last = (cfg_q.len == '0) || (idx_q == cfg_q.len - LW'(1));
        unique case (cfg_q.mode)
            PAT_CONST: v_d = v_q;
            PAT_RAMP:  v_d = v_q + cfg_q.step;
            PAT_WALK:  v_d = {v_q[DW-2:0], v_q[DW-1]};
            PAT_SAW: begin
                if (saw_last) begin
                    v_d   = '0;
                    idx_d = '0;
                end else begin
                    v_d   = v_q + cfg_q.step;
                    idx_d = idx_q + LW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            cfg_q    <= '0;
            v_q      <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q  <= RUN;
                        cfg_q    <= cfg_d;
                        v_q      <= first_sample(cfg_d.mode, cfg_d.val);
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        tvalid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (hs) begin
                        cnt_q <= cnt_q + 32'd1;
                        v_q   <= v_d;
                        idx_q <= idx_d;
                    end
                    if (ctl_stop_i) begin
                        if (hs) begin
                            state_q  <= IDLE;
                            tvalid_q <= 1'b0;
                        end else begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (hs) begin
                        cnt_q    <= cnt_q + 32'd1;
                        v_q      <= v_d;
                        idx_q    <= idx_d;
                        state_q  <= IDLE;
                        tvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    tvalid_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar c = 0; c < CN; c++) begin : g_ch
        assign m_tdata_o[c*DW +: DW] = v_q ^ {DW{cfg_q.inv[c]}};
    end

    adc_pattern_trg #(
        .PW(PW)
    ) u_trg (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (trg_en),
        .clr_i  (start_ok),
        .per_i  (cfg_q.per),
        .len_i  (cfg_q.tlen),
        .trg_o  (trg_o)
    );

    assign sts_run_o  = (state_q != IDLE);
    assign sts_cnt_o  = cnt_q;
    assign m_tvalid_o = tvalid_q;

endmodule

// File: tb/tb_adc_pattern_gen.sv
// Scoreboard bench for adc_pattern_gen: expected beats are queued by the
// stimulus and popped by a negedge monitor on every handshake.
module tb_adc_pattern_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  mode = '0;
    logic [13:0] val = '0;
    logic [13:0] step = '0;
    logic [15:0] len = '0;
    logic [1:0]  inv = '0;
    logic [31:0] per = '0;
    logic [31:0] tlen = '0;
    logic        tready = 1'b0;
    logic        run;
    logic [31:0] cnt;
    logic [27:0] tdata;
    logic        tvalid;
    logic        trg;

    logic [27:0] expq[$];
    int          total = 0;
    int          bad = 0;
    logic        stall_q = 1'b0;
    logic [27:0] stall_d = '0;

    always #5 clk = ~clk;

    adc_pattern_gen dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .ctl_start_i   (start),
        .ctl_stop_i    (stop),
        .cfg_mode_i    (mode),
        .cfg_val_i     (val),
        .cfg_step_i    (step),
        .cfg_len_i     (len),
        .cfg_inv_i     (inv),
        .cfg_trg_per_i (per),
        .cfg_trg_len_i (tlen),
        .sts_run_o     (run),
        .sts_cnt_o     (cnt),
        .m_tdata_o     (tdata),
        .m_tvalid_o    (tvalid),
        .m_tready_i    (tready),
        .trg_o         (trg)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] mk(input logic [13:0] v,
                                       input logic [1:0] i);
        return {v ^ {14{i[1]}}, v ^ {14{i[0]}}};
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            stall_q <= 1'b0;
        end else begin
            if (stall_q && tvalid)
                chk("hold", 64'(tdata), 64'(stall_d));
            if (tvalid && tready) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat got=%0h want=none", tdata);
                end else begin
                    chk("beat", 64'(tdata), 64'(expq.pop_front()));
                end
            end
            stall_q <= tvalid && !tready;
            stall_d <= tdata;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setcfg(input logic [1:0] m, input logic [13:0] v,
                          input logic [13:0] s, input logic [15:0] l,
                          input logic [1:0] i, input logic [31:0] p,
                          input logic [31:0] t);
        mode = m; val = v; step = s; len = l;
        inv = i; per = p; tlen = t;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop_hs;
        stop = 1'b1;
        tready = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_tvalid", 64'(tvalid), 0);
        chk("stop_run", 64'(run), 0);
    endtask

    task automatic trg_run(input logic [31:0] p, input logic [31:0] t,
                           input int n);
        logic e;
        setcfg(2'd0, 14'h155, 14'd0, 16'd0, 2'b01, p, t);
        tready = 1'b0;
        expq.push_back(mk(14'h155, 2'b01));
        do_start();
        for (int k = 1; k <= n; k++) begin
            tick();
            e = (p == 0) ? 1'b0 : (((k - 1) % p) < t);
            chk("trg", 64'(trg), 64'(e));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("trg_stop", 64'(trg), 0);
        chk("stop_hold_run", 64'(run), 1);
        tready = 1'b1;
        tick();
        chk("trg_idle_tvalid", 64'(tvalid), 0);
        chk("trg_idle_run", 64'(run), 0);
        tready = 1'b0;
    endtask

    initial begin
        int hs;
        int i;
        logic [3:0] pat;
        pat = 4'b1001;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(tvalid), 0);
        chk("rst_trg", 64'(trg), 0);
        chk("rst_run", 64'(run), 0);
        chk("rst_cnt", 64'(cnt), 0);
        chk("rst_tdata", 64'(tdata), 0);
        rstn = 1'b1;
        tick();

        // Ramp with channel-1 inversion, through the 14-bit wrap.
        setcfg(2'd1, 14'd0, 14'd4, 16'd0, 2'b10, 32'd0, 32'd0);
        for (int k = 0; k <= 4096; k++)
            expq.push_back(mk(14'(4 * k), 2'b10));
        tready = 1'b1;
        do_start();
        chk("ramp_cnt0", 64'(cnt), 0);
        chk("ramp_tvalid", 64'(tvalid), 1);
        repeat (4096) tick();
        chk("ramp_cnt", 64'(cnt), 4096);
        chk("ramp_wrap", 64'(tdata[13:0]), 0);
        do_stop_hs();
        chk("ramp_cnt_end", 64'(cnt), 4097);

        // Sawtooth, length 30.
        setcfg(2'd3, 14'd9, 14'd4, 16'd30, 2'b00, 32'd0, 32'd0);
        for (int k = 0; k < 32; k++)
            expq.push_back(mk(14'((k % 30) * 4), 2'b00));
        do_start();
        repeat (31) tick();
        do_stop_hs();

        // Sawtooth, length 0 acts as constant zero.
        setcfg(2'd3, 14'd7, 14'd4, 16'd0, 2'b00, 32'd0, 32'd0);
        for (int k = 0; k < 5; k++)
            expq.push_back(mk(14'd0, 2'b00));
        do_start();
        repeat (4) tick();
        do_stop_hs();

        // Walking one with back-pressure, then stop while stalled.
        setcfg(2'd2, 14'd0, 14'd0, 16'd0, 2'b00, 32'd4, 32'd2);
        for (int k = 0; k <= 16; k++)
            expq.push_back(mk(14'(1 << (k % 14)), 2'b00));
        do_start();
        hs = 0;
        i = 0;
        while (hs < 16 && i < 400) begin
            tready = pat[i % 4];
            if (tvalid && tready)
                hs++;
            tick();
            i++;
        end
        chk("walk_budget", 64'(hs), 16);
        stop = 1'b1;
        tready = 1'b0;
        tick();
        stop = 1'b0;
        chk("walk_stop_run", 64'(run), 1);
        chk("walk_stop_tvalid", 64'(tvalid), 1);
        chk("walk_stop_trg", 64'(trg), 0);
        repeat (3) tick();
        chk("walk_stop_data", 64'(tdata[13:0]), 4);
        tready = 1'b1;
        tick();
        chk("walk_idle_tvalid", 64'(tvalid), 0);
        chk("walk_idle_run", 64'(run), 0);
        chk("walk_cnt", 64'(cnt), 17);
        tready = 1'b0;

        // Trigger shapes.
        trg_run(32'd100, 32'd12, 350);
        trg_run(32'd10, 32'd15, 40);
        trg_run(32'd0, 32'd5, 40);

        // Start and stop together in IDLE: nothing happens.
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("ss_run", 64'(run), 0);
        chk("ss_tvalid", 64'(tvalid), 0);

        // Asynchronous reset mid-run.
        setcfg(2'd1, 14'd5, 14'd1, 16'd0, 2'b00, 32'd4, 32'd2);
        expq.push_back(mk(14'd5, 2'b00));
        expq.push_back(mk(14'd6, 2'b00));
        tready = 1'b1;
        do_start();
        tick();
        tick();
        chk("pre_rst_trg", 64'(trg), 1);
        chk("pre_rst_tvalid", 64'(tvalid), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_tvalid", 64'(tvalid), 0);
        chk("arst_trg", 64'(trg), 0);
        chk("arst_run", 64'(run), 0);
        chk("arst_cnt", 64'(cnt), 0);
        chk("arst_queue", 64'(expq.size()), 0);
        #10;
        rstn = 1'b1;
        tick();
        expq.push_back(mk(14'd5, 2'b00));
        do_start();
        chk("restart_cnt", 64'(cnt), 0);
        chk("restart_data", 64'(tdata[13:0]), 5);
        do_stop_hs();
        chk("restart_cnt_end", 64'(cnt), 1);

        tick();
        chk("queue_empty", 64'(expq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
